// File: rtl/divisible_by_n_pkg.sv
// Shared helpers for the divisible_by_n running-sum tracker: width maths,
// lane popcount and parameter legality.
package div_n_pkg;

  // Smallest w with 2**w >= v (0 for v <= 1).
  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

  // Width of a value held modulo n, never below one bit.
  function automatic int rem_w(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

  // Subtraction stages needed to fully reduce any sumw-bit value modulo n.
  function automatic int reduce_stages(input int n, input int sumw);
    return ((1 << sumw) - 1 + n - 1) / n;
  endfunction

  // Width of the quotient produced by those stages.
  function automatic int reduce_qw(input int n, input int sumw);
    return (clog2(reduce_stages(n, sumw) + 1) < 1) ? 1 : clog2(reduce_stages(n, sumw) + 1);
  endfunction

  // Number of set bits in a lane vector (up to 32 lanes).
  function automatic int popcount(input logic [31:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 32; i++) c += int'(v[i]);
    return c;
  endfunction

  // Legal configuration: modulus of at least 2, at least one lane.
  function automatic bit params_ok(input int n, input int lanes);
    return (n >= 2) && (lanes >= 1);
  endfunction

endpackage

// File: rtl/divisible_by_n_if.sv
// Stream-side bundle of the divisibility tracker: lane inputs with
// qualification/clear, and the registered status outputs.
interface divisible_by_n_if
  import div_n_pkg::*;
#(
  parameter int LANES = 2,
  parameter int RW    = 3,
  parameter int WRAPW = 8
);
  logic             i_clear;
  logic             i_in_valid;
  logic [LANES-1:0] i_lanes;
  logic [RW-1:0]    o_remainder;
  logic             o_divisible;
  logic             o_wrap;
  logic [WRAPW-1:0] o_wrap_count;
  logic             o_wrap_ovf;

  modport master (
    output i_clear, i_in_valid, i_lanes,
    input  o_remainder, o_divisible, o_wrap, o_wrap_count, o_wrap_ovf
  );

  modport slave (
    input  i_clear, i_in_valid, i_lanes,
    output o_remainder, o_divisible, o_wrap, o_wrap_count, o_wrap_ovf
  );
endinterface

// File: rtl/divisible_by_n_reduce.sv
// Combinational modulo-N reduction of a bounded sum by a chain of
// conditional subtractions; no divider is inferred.
module mod_n_reduce
  import div_n_pkg::*;
#(
  parameter int N    = 6,
  parameter int SUMW = 3
) (
  input  logic [SUMW-1:0]                   i_sum,
  output logic [rem_w(N)-1:0]               o_r,
  output logic [reduce_qw(N, SUMW)-1:0]     o_q
);
  localparam int RW = rem_w(N);
  localparam int K  = reduce_stages(N, SUMW);
  localparam int QW = reduce_qw(N, SUMW);

  // Peel off one multiple of N per stage, counting how many were removed.
  always_comb begin
    logic [SUMW-1:0] w_v;
    logic [QW-1:0]   w_c;
    w_v = i_sum;
    w_c = '0;
    for (int s = 0; s < K; s++) begin
      if (w_v >= SUMW'(N)) begin
        w_v = w_v - SUMW'(N);
        w_c = w_c + QW'(1);
      end
    end
    o_r = RW'(w_v);
    o_q = w_c;
  end
endmodule

// File: rtl/divisible_by_n.sv
// Running-sum divisibility tracker: accumulates lane popcounts modulo N,
// flags multiples and keeps a saturating count of multiples crossed.
module divisible_by_n
  import div_n_pkg::*;
#(
  parameter int N     = 6,
  parameter int LANES = 2,
  parameter int WRAPW = 8
) (
  input  logic           clk,
  input  logic           reset,
  divisible_by_n_if.slave bus
);
  localparam int RW   = rem_w(N);
  localparam int PW   = clog2(LANES + 1);
  localparam int SUMW = clog2(N + LANES);
  localparam int QW   = reduce_qw(N, SUMW);
  localparam int AW   = WRAPW + QW + 1;

  if (!params_ok(N, LANES) || (WRAPW < 1)) begin : g_param_err
    $error("divisible_by_n: illegal parameters N=%0d LANES=%0d WRAPW=%0d", N, LANES, WRAPW);
  end

  // Adds q to the wrap count, clamping at all-ones; MSB of the result flags discarded wraps.
  function automatic logic [WRAPW:0] sat_add(input logic [WRAPW-1:0] cnt, input logic [QW-1:0] q);
    logic [AW-1:0] wide;
    logic [AW-1:0] lim;
    wide = AW'(cnt) + AW'(q);
    lim  = AW'({WRAPW{1'b1}});
    if (wide > lim) return {1'b1, {WRAPW{1'b1}}};
    return {1'b0, wide[WRAPW-1:0]};
  endfunction

  logic [RW-1:0]    r_remainder;
  logic             r_wrap;
  logic [WRAPW-1:0] r_wrap_count;
  logic             r_wrap_ovf;

  logic [PW-1:0]    w_pop;
  logic [SUMW-1:0]  w_sum;
  logic [RW-1:0]    w_r;
  logic [QW-1:0]    w_q;
  logic [WRAPW:0]   w_sat;
  logic             w_illegal;

  assign w_pop     = PW'(popcount(32'(bus.i_lanes)));
  assign w_sum     = SUMW'(r_remainder) + SUMW'(w_pop);
  assign w_sat     = sat_add(r_wrap_count, w_q);
  // Encodings N..2**RW-1 cannot arise in normal operation; they are flushed rather than reduced.
  assign w_illegal = ({1'b0, r_remainder} >= (RW + 1)'(N));

  mod_n_reduce #(.N(N), .SUMW(SUMW)) u_reduce (
    .i_sum (w_sum),
    .o_r   (w_r),
    .o_q   (w_q)
  );

  // State update: async reset, then clear, then qualified accumulate, else hold.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_remainder  <= '0;
      r_wrap       <= 1'b0;
      r_wrap_count <= '0;
      r_wrap_ovf   <= 1'b0;
    end else if (bus.i_clear) begin
      r_remainder  <= '0;
      r_wrap       <= 1'b0;
      r_wrap_count <= '0;
      r_wrap_ovf   <= 1'b0;
    end else if (bus.i_in_valid) begin
      if (w_illegal) begin
        r_remainder <= '0;
        r_wrap      <= 1'b0;
      end else begin
        r_remainder  <= w_r;
        r_wrap       <= (w_q != '0);
        r_wrap_count <= w_sat[WRAPW-1:0];
        r_wrap_ovf   <= r_wrap_ovf | w_sat[WRAPW];
      end
    end else begin
      r_wrap <= 1'b0;
    end
  end

  assign bus.o_remainder  = r_remainder;
  assign bus.o_divisible  = (r_remainder == '0);
  assign bus.o_wrap       = r_wrap;
  assign bus.o_wrap_count = r_wrap_count;
  assign bus.o_wrap_ovf   = r_wrap_ovf;
endmodule
